// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: misalign/illegal detection, byte enables and store replication
// for the issuing access, plus extract/extend of the returned load word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic        mis,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] bus_rdata,
    output logic [31:0] ld_data
);

    logic        illegal;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // 011 and 11x are never legal; unsigned sizes only exist for loads
    assign illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);

    always_comb begin
        mis       = illegal;
        be        = 4'b1111;
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                mis       = illegal | off[0];
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: mis = illegal | (off != 2'b00);
        endcase
    end

    assign ld_byte = bus_rdata[{ld_off, 3'b000} +: 8];
    assign ld_half = ld_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        case (ld_funct3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LBU:  ld_data = {24'd0, ld_byte};
            F3_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: issues one req/ack bus access per load/store, stalls the core
// while it is in flight, and returns formatted load data.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        err_sticky,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        access_req, mis_raw, to_hit;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, ld_data;

    lsu_lane_align u_align (
        .funct3    (funct3),
        .is_store  (mem_write),
        .off       (addr[1:0]),
        .wdata     (wdata),
        .mis       (mis_raw),
        .be        (be_c),
        .wdata_rep (wdata_c),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .bus_rdata (bus_rdata),
        .ld_data   (ld_data)
    );

    assign access_req = mem_read | mem_write;
    assign misalign   = access_req & mis_raw;
    assign bus_req    = (state == ACCESS);
    assign to_hit     = (state == ACCESS) && !bus_ack && (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: if (access_req && !mis_raw) begin
                // reset is already holding state in IDLE; keep stall quiet too
                stall     = ~reset;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                stall = 1'b1;
                if (bus_ack || to_hit) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rdata      <= '0;
            err_sticky <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            f3_q       <= '0;
            off_q      <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == ACCESS) ? cnt + 16'd1 : 16'd0;
            case (state)
                IDLE: if (access_req) begin
                    if (mis_raw) begin
                        err_sticky <= 1'b1;
                    end else begin
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= be_c;
                        bus_wdata <= wdata_c;
                        bus_we    <= mem_write;
                        f3_q      <= funct3;
                        off_q     <= addr[1:0];
                    end
                end
                ACCESS: begin
                    if (bus_ack) begin
                        if (!bus_we) rdata <= ld_data;
                    end else if (to_hit) begin
                        err_sticky <= 1'b1;
                        if (!bus_we) rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: table of single accesses with a scoreboard of expected
// bus/rdata results, plus hand sequences for late ack and mid-access reset.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    localparam int TO     = 4;
    localparam int NO_ACK = 99;
    localparam int NVEC   = 18;

    logic        clk, reset, mem_read, mem_write, bus_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, bus_rdata;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        stall, misalign, err_sticky, bus_req, bus_we;

    lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .misalign(misalign), .err_sticky(err_sticky), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;
        int          wt;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rdx;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
        logic [31:0] rd;
    } exp_t;

    vec_t        tbl [NVEC];
    exp_t        sb [$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] rd_model = '0;
    logic        err_model = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   stalls, reqs;
        e.addr = {v.addr[31:2], 2'b00};
        e.be   = v.be;
        e.wd   = v.wd;
        e.we   = v.wr;
        if (v.mis || v.wr)     e.rd = rd_model;
        else if (v.wt == NO_ACK) e.rd = '0;
        else                   e.rd = v.rdx;
        sb.push_back(e);

        @(posedge clk); #1;
        mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        @(negedge clk);
        chk("misalign", misalign, v.mis);
        stalls = 0;
        reqs   = 0;
        if (v.mis) begin
            chk("mis_stall", stall, 0);
            chk("mis_req", bus_req, 0);
            @(posedge clk); #1;
            mem_read = 0; mem_write = 0;
            @(negedge clk);
            chk("mis_req_after", bus_req, 0);
        end else begin
            while (stall && stalls < 40) begin
                stalls++;
                if (bus_req) begin
                    reqs++;
                    chk("bus_addr", bus_addr, sb[0].addr);
                    chk("bus_be", bus_be, sb[0].be);
                    chk("bus_we", bus_we, sb[0].we);
                    if (sb[0].we) chk("bus_wdata", bus_wdata, sb[0].wd);
                    if (reqs == v.wt + 1) begin
                        bus_ack   = 1'b1;
                        bus_rdata = v.brd;
                    end
                end
                @(posedge clk); #1;
                bus_ack   = 1'b0;
                bus_rdata = 32'h5A5A_5A5A;
                @(negedge clk);
            end
            chk("stall_cycles", stalls, (v.wt == NO_ACK) ? TO + 1 : v.wt + 2);
            chk("req_cycles", reqs, (v.wt == NO_ACK) ? TO : v.wt + 1);
            chk("resp_req", bus_req, 0);
        end
        e = sb.pop_front();
        chk("rdata", rdata, e.rd);
        rd_model  = e.rd;
        err_model = err_model | v.mis | (v.wt == NO_ACK);
        chk("err_sticky", err_sticky, err_model);
        if (!v.mis) begin
            @(posedge clk); #1;
            mem_read = 0; mem_write = 0;
        end
    endtask

    initial begin
        //           rd    wr    f3      addr         wdata         brd           wt      mis   be       wd            rdx
        tbl[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,      1'b0, 4'b1111, 32'h0,        32'hDEADBEEF};
        tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 1,      1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
        tbl[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80112233, 0,      1'b0, 4'b1000, 32'h0,        32'h00000080};
        tbl[3]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0,        3,      1'b0, 4'b1100, 32'hABCDABCD, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 0,      1'b0, 4'b1100, 32'h0,        32'hFFFF8001};
        tbl[5]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h8001F00F, 2,      1'b0, 4'b0011, 32'h0,        32'h0000F00F};
        tbl[6]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h123456A5, 32'h0,        0,      1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0,        1,      1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};
        tbl[8]  = '{1'b1, 1'b1, 3'b010, 32'h400, 32'h11223344, 32'hDEADDEAD, 0,      1'b0, 4'b1111, 32'h11223344, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 3'b000, 32'h100, 32'h0,        32'h0000007F, 0,      1'b0, 4'b0001, 32'h0,        32'h0000007F};
        tbl[10] = '{1'b1, 1'b0, 3'b010, 32'h500, 32'h0,        32'h0,        NO_ACK, 1'b0, 4'b1111, 32'h0,        32'h0};
        tbl[11] = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h00008000, 0,      1'b0, 4'b0011, 32'h0,        32'hFFFF8000};
        tbl[12] = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0,      1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[13] = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0,      1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[14] = '{1'b0, 1'b1, 3'b001, 32'h201, 32'h0,        32'h0,        0,      1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[15] = '{1'b0, 1'b1, 3'b100, 32'h200, 32'h0,        32'h0,        0,      1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[16] = '{1'b1, 1'b0, 3'b101, 32'h103, 32'h0,        32'h0,        0,      1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[17] = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'hBEEF1234, 0,      1'b0, 4'b1100, 32'h0,        32'h0000BEEF};

        reset = 1'b1; mem_read = 0; mem_write = 0; funct3 = '0; addr = '0; wdata = '0;
        bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_be", bus_be, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_err", err_sticky, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            if (i == 11) begin
                // ack arriving in IDLE after a timeout must not touch rdata
                @(posedge clk); #1;
                bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
                @(posedge clk); #1;
                bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
                @(negedge clk);
                chk("late_ack_req", bus_req, 0);
                chk("late_ack_stall", stall, 0);
                chk("late_ack_rdata", rdata, rd_model);
            end
            if (i == 12) begin
                @(posedge clk); #1;
                mem_read = 1; funct3 = F3_LW; addr = 32'h600;
                @(posedge clk); #1;
                @(negedge clk);
                chk("mid_pre_req", bus_req, 1);
                #2;
                reset = 1'b1; mem_read = 0;
                #1;
                chk("mid_rst_req", bus_req, 0);
                chk("mid_rst_stall", stall, 0);
                chk("mid_rst_rdata", rdata, 0);
                chk("mid_rst_err", err_sticky, 0);
                chk("mid_rst_be", bus_be, 0);
                @(posedge clk); #1;
                reset = 1'b0;
                bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
                @(posedge clk); #1;
                bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
                @(negedge clk);
                chk("post_rst_ack_req", bus_req, 0);
                chk("post_rst_ack_rdata", rdata, 0);
                rd_model  = '0;
                err_model = 1'b0;
            end
            run_vec(tbl[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
